ptc_mfb_frame_len_meter: RTL and testbench
==========================================

# ptc_mfb_frame_len_meter

Pipeline stage directly downstream of the PTC frame eraser. It measures the length, in items, of every MFB frame after header removal. Data and framing pass through unchanged. At each frame's EOF region it emits a per-region length word alongside the data, so the following DMA/split logic gets payload length without recounting. Latency is one register stage, with full MFB backpressure support.

## Interface
Parameters:
- REGIONS, 2, number of MFB regions per word
- REGION_SIZE, 1, blocks per region
- BLOCK_SIZE, 8, items per block
- ITEM_WIDTH, 32, bits per item
- LEN_WIDTH, 16, width of the reported length per region

Ports:
- CLK  in  1  clock
- RESET_N  in  1  asynchronous, active-low reset
- RX_DATA  in  REGIONS*REGION_SIZE*BLOCK_SIZE*ITEM_WIDTH  frame data
- RX_SOF_POS  in  REGIONS*max(1,log2(REGION_SIZE))  SOF block index per region
- RX_EOF_POS  in  REGIONS*log2(REGION_SIZE*BLOCK_SIZE)  EOF item index per region
- RX_SOF, RX_EOF  in  REGIONS  per-region start/end flags
- RX_SRC_RDY  in  1  input word valid
- RX_DST_RDY  out  1  stage can accept a word
- TX_DATA, TX_SOF_POS, TX_EOF_POS, TX_SOF, TX_EOF  out  same widths as RX  registered copies of the RX signals
- TX_LEN  out  REGIONS*LEN_WIDTH  frame length for each region where TX_EOF=1
- TX_LEN_SAT  out  REGIONS  length saturated
- TX_SRC_RDY  out  1  output valid
- TX_DST_RDY  in  1  downstream ready

## Operation
Definitions:
- RI = REGION_SIZE*BLOCK_SIZE; W = REGIONS*RI.
- Region r base index = r*RI.
- SOF item index = base + SOF_POS*BLOCK_SIZE.
- EOF item index = base + EOF_POS.

State:
- in_frame (1 bit): a frame is open across the word boundary.
- acc (LEN_WIDTH+1 bits): items of the open frame counted in earlier words.

Per accepted word, regions are walked in ascending order with a running (open, start, carry) tuple. At word start this is open=in_frame, start=0, carry=acc.
- A region with both SOF and EOF:
  - If open on entry, EOF is processed first, then SOF.
  - Otherwise SOF is processed first (a whole frame in the region).
- SOF: open=1, start=SOF index, carry=0.
- EOF while open:
  - len = carry + EOF index + 1 − start.
  - If len > 2^LEN_WIDTH−1, TX_LEN=all-ones and TX_LEN_SAT=1.
  - open=0.
- EOF while not open (orphan): TX_LEN=0, TX_LEN_SAT=0; data still passes.
- At word end:
  - If open: in_frame=1, acc=min(carry + W − start, 2^LEN_WIDTH), with sticky saturation.
  - Else: in_frame=0, acc=0.
- TX_LEN/TX_LEN_SAT of regions without TX_EOF are 0.
- State updates only when RX_SRC_RDY and RX_DST_RDY are both 1.

## Timing
- Single output register stage; latency is 1 cycle from RX acceptance to TX_SRC_RDY.
- RX_DST_RDY = TX_DST_RDY or not TX_SRC_RDY. Combinational; no bubble at full throughput.
- The output register loads when RX_DST_RDY=1. TX_SRC_RDY is then set to RX_SRC_RDY.
- While TX_SRC_RDY=1 and TX_DST_RDY=0, all TX outputs hold stable.
- Reset (asynchronous assert, synchronous-safe deassert):
  - TX_SRC_RDY=0; TX_SOF/TX_EOF/TX_LEN/TX_LEN_SAT/TX_DATA/TX_*_POS = 0.
  - in_frame=0, acc=0.
  - A frame open at reset is forgotten; its later EOF is an orphan.
- Simultaneous EOF and SOF in one region: EOF closes the old frame and SOF opens the new one in the same cycle. No stall.
- Saturation is sticky for the frame until its EOF.

## Structure
- A shared package (ptc_frame_pkg) holds the derived constants RI, W, SOF_POS_W, EOF_POS_W, and the helper that computes the region base index.
- One sub-module, ptc_mfb_len_region_step: combinational per-region update of (open, start, carry) → (len, sat, open', start', carry').
  - Instantiated REGIONS times in a chain.
  - The top holds in_frame/acc and the output register.

## Test plan
Default parameters unless noted (W=16).
- Region 0: SOF_POS=0, EOF_POS=5 → next cycle TX_EOF=01, TX_LEN[0]=6, TX_LEN[1]=0.
- Frame spanning words: SOF in region 1, then one full word, then EOF in region 0 with EOF_POS=3 → TX_LEN[0]=8+16+4=28.
- One word with EOF in region 0 at EOF_POS=7 (frame opened at item 8 of the previous word) and SOF+EOF in region 1 at EOF_POS=2 → TX_LEN[0]=16, TX_LEN[1]=3.
- Backpressure: TX_DST_RDY=0 for 5 cycles during a 3-word frame.
  - RX_DST_RDY drops after one word is buffered and TX outputs hold.
  - After release, the reported length equals the unstalled value; no word lost or duplicated.
- LEN_WIDTH=6 with an 80-item frame → TX_LEN=63, TX_LEN_SAT=1.
- Assert RESET_N=0 mid-frame → all TX outputs 0. After release, an EOF at region 0 EOF_POS=4 with no SOF → TX_LEN[0]=0 and data passed unchanged.

Source files
------------

// File: rtl/ptc_frame_pkg.sv
// Derived MFB geometry shared by the PTC frame length meter, its region step and its bus interface.
package ptc_frame_pkg;

  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  function automatic int calc_ri(input int region_size, input int block_size);
    return region_size * block_size;
  endfunction

  function automatic int calc_w(input int regions, input int region_size, input int block_size);
    return regions * region_size * block_size;
  endfunction

  function automatic int calc_sof_pos_w(input int region_size);
    return clog2_min1(region_size);
  endfunction

  function automatic int calc_eof_pos_w(input int region_size, input int block_size);
    return clog2_min1(region_size * block_size);
  endfunction

  function automatic int region_base(input int region, input int region_size, input int block_size);
    return region * region_size * block_size;
  endfunction

  localparam int DEF_REGIONS     = 2;
  localparam int DEF_REGION_SIZE = 1;
  localparam int DEF_BLOCK_SIZE  = 8;
  localparam int RI        = calc_ri(DEF_REGION_SIZE, DEF_BLOCK_SIZE);
  localparam int W         = calc_w(DEF_REGIONS, DEF_REGION_SIZE, DEF_BLOCK_SIZE);
  localparam int SOF_POS_W = calc_sof_pos_w(DEF_REGION_SIZE);
  localparam int EOF_POS_W = calc_eof_pos_w(DEF_REGION_SIZE, DEF_BLOCK_SIZE);

endpackage

// File: rtl/ptc_mfb_frame_len_meter_if.sv
// MFB bus bundle (data, framing, handshake); master drives the word, slave returns ready.
interface ptc_mfb_frame_len_meter_if
  import ptc_frame_pkg::*;
#(
  parameter int REGIONS     = 2,
  parameter int REGION_SIZE = 1,
  parameter int BLOCK_SIZE  = 8,
  parameter int ITEM_WIDTH  = 32
) ();

  localparam int DATA_W = REGIONS * REGION_SIZE * BLOCK_SIZE * ITEM_WIDTH;
  localparam int SOF_PW = calc_sof_pos_w(REGION_SIZE);
  localparam int EOF_PW = calc_eof_pos_w(REGION_SIZE, BLOCK_SIZE);

  logic [DATA_W-1:0]         data;
  logic [REGIONS*SOF_PW-1:0] sof_pos;
  logic [REGIONS*EOF_PW-1:0] eof_pos;
  logic [REGIONS-1:0]        sof;
  logic [REGIONS-1:0]        eof;
  logic                      src_rdy;
  logic                      dst_rdy;

  modport master (output data, sof_pos, eof_pos, sof, eof, src_rdy, input dst_rdy);
  modport slave  (input data, sof_pos, eof_pos, sof, eof, src_rdy, output dst_rdy);

endinterface

// File: rtl/ptc_mfb_len_region_step.sv
// One region of the length walk: folds this region's SOF/EOF into the running (open, start, carry).
module ptc_mfb_len_region_step
  import ptc_frame_pkg::*;
#(
  parameter int REGION      = 0,
  parameter int REGIONS     = 2,
  parameter int REGION_SIZE = 1,
  parameter int BLOCK_SIZE  = 8,
  parameter int LEN_WIDTH   = 16,
  localparam int SOF_PW = calc_sof_pos_w(REGION_SIZE),
  localparam int EOF_PW = calc_eof_pos_w(REGION_SIZE, BLOCK_SIZE),
  localparam int IDX_W  = clog2_min1(calc_w(REGIONS, REGION_SIZE, BLOCK_SIZE))
) (
  input  logic                 open_in,
  input  logic [IDX_W-1:0]     start_in,
  input  logic [LEN_WIDTH:0]   carry_in,
  input  logic                 sof,
  input  logic                 eof,
  input  logic [SOF_PW-1:0]    sof_pos,
  input  logic [EOF_PW-1:0]    eof_pos,
  output logic [LEN_WIDTH-1:0] len,
  output logic                 sat,
  output logic                 open_out,
  output logic [IDX_W-1:0]     start_out,
  output logic [LEN_WIDTH:0]   carry_out
);

  localparam int SW   = LEN_WIDTH + 2 + IDX_W;
  localparam int BASE = region_base(REGION, REGION_SIZE, BLOCK_SIZE);
  localparam logic [SW-1:0] LEN_MAX = {{(SW-LEN_WIDTH){1'b0}}, {LEN_WIDTH{1'b1}}};

  logic [IDX_W-1:0] sof_idx;
  logic [IDX_W-1:0] eof_idx;
  logic [SW-1:0]    end_sum;
  logic [SW-1:0]    span;
  logic             sof_first;

  assign sof_idx = IDX_W'(BASE + int'(sof_pos) * BLOCK_SIZE);
  assign eof_idx = IDX_W'(BASE + int'(eof_pos));

  // An open frame must be closed before a new SOF in the same region may reopen it.
  always_comb begin
    sof_first = sof && !open_in;
    open_out  = open_in;
    start_out = start_in;
    carry_out = carry_in;
    len       = '0;
    sat       = 1'b0;
    end_sum   = '0;
    span      = '0;
    if (sof_first) begin
      open_out  = 1'b1;
      start_out = sof_idx;
      carry_out = '0;
    end
    if (eof) begin
      if (open_out) begin
        end_sum = SW'(carry_out) + SW'(eof_idx) + SW'(1);
        span    = (end_sum > SW'(start_out)) ? end_sum - SW'(start_out) : '0;
        if (span > LEN_MAX) begin
          len = '1;
          sat = 1'b1;
        end else begin
          len = span[LEN_WIDTH-1:0];
        end
      end
      open_out  = 1'b0;
      start_out = '0;
      carry_out = '0;
    end
    if (sof && !sof_first) begin
      open_out  = 1'b1;
      start_out = sof_idx;
      carry_out = '0;
    end
  end

endmodule

// File: rtl/ptc_mfb_frame_len_meter.sv
// Passes MFB words through one register stage and reports each frame's item count at its EOF region.
module ptc_mfb_frame_len_meter
  import ptc_frame_pkg::*;
#(
  parameter int REGIONS     = 2,
  parameter int REGION_SIZE = 1,
  parameter int BLOCK_SIZE  = 8,
  parameter int ITEM_WIDTH  = 32,
  parameter int LEN_WIDTH   = 16
) (
  input  logic                         CLK,
  input  logic                         RESET_N,
  ptc_mfb_frame_len_meter_if.slave     rx,
  ptc_mfb_frame_len_meter_if.master    tx,
  output logic [REGIONS*LEN_WIDTH-1:0] TX_LEN,
  output logic [REGIONS-1:0]           TX_LEN_SAT
);

  localparam int WORD   = calc_w(REGIONS, REGION_SIZE, BLOCK_SIZE);
  localparam int DATA_W = WORD * ITEM_WIDTH;
  localparam int SOF_PW = calc_sof_pos_w(REGION_SIZE);
  localparam int EOF_PW = calc_eof_pos_w(REGION_SIZE, BLOCK_SIZE);
  localparam int IDX_W  = clog2_min1(WORD);
  localparam int CW     = LEN_WIDTH + 1;
  localparam int SW     = CW + IDX_W + 1;
  localparam logic [CW-1:0] ACC_MAX = {1'b1, {LEN_WIDTH{1'b0}}};

  logic            in_frame;
  logic [CW-1:0]   acc;
  logic            open_c  [REGIONS+1];
  logic [IDX_W-1:0] start_c [REGIONS+1];
  logic [CW-1:0]   carry_c [REGIONS+1];
  logic [REGIONS*LEN_WIDTH-1:0] len_w;
  logic [REGIONS-1:0]           sat_w;
  logic [SW-1:0]   acc_sum;
  logic [CW-1:0]   acc_next;
  logic            load;
  logic            tx_vld;

  logic [DATA_W-1:0]         data_q;
  logic [REGIONS*SOF_PW-1:0] sof_pos_q;
  logic [REGIONS*EOF_PW-1:0] eof_pos_q;
  logic [REGIONS-1:0]        sof_q;
  logic [REGIONS-1:0]        eof_q;

  assign open_c[0]  = in_frame;
  assign start_c[0] = '0;
  assign carry_c[0] = acc;

  for (genvar r = 0; r < REGIONS; r++) begin : g_step
    ptc_mfb_len_region_step #(
      .REGION      (r),
      .REGIONS     (REGIONS),
      .REGION_SIZE (REGION_SIZE),
      .BLOCK_SIZE  (BLOCK_SIZE),
      .LEN_WIDTH   (LEN_WIDTH)
    ) u_step (
      .open_in   (open_c[r]),
      .start_in  (start_c[r]),
      .carry_in  (carry_c[r]),
      .sof       (rx.sof[r]),
      .eof       (rx.eof[r]),
      .sof_pos   (rx.sof_pos[r*SOF_PW +: SOF_PW]),
      .eof_pos   (rx.eof_pos[r*EOF_PW +: EOF_PW]),
      .len       (len_w[r*LEN_WIDTH +: LEN_WIDTH]),
      .sat       (sat_w[r]),
      .open_out  (open_c[r+1]),
      .start_out (start_c[r+1]),
      .carry_out (carry_c[r+1])
    );
  end

  // Clamping the carry at 2^LEN_WIDTH keeps saturation sticky without a separate flag.
  always_comb begin
    acc_sum  = SW'(carry_c[REGIONS]) + SW'(WORD) - SW'(start_c[REGIONS]);
    acc_next = (acc_sum > SW'(ACC_MAX)) ? ACC_MAX : acc_sum[CW-1:0];
  end

  assign load       = tx.dst_rdy || !tx_vld;
  assign rx.dst_rdy = load;
  assign tx.src_rdy = tx_vld;
  assign tx.data    = data_q;
  assign tx.sof_pos = sof_pos_q;
  assign tx.eof_pos = eof_pos_q;
  assign tx.sof     = sof_q;
  assign tx.eof     = eof_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      tx_vld     <= 1'b0;
      data_q     <= '0;
      sof_pos_q  <= '0;
      eof_pos_q  <= '0;
      sof_q      <= '0;
      eof_q      <= '0;
      TX_LEN     <= '0;
      TX_LEN_SAT <= '0;
      in_frame   <= 1'b0;
      acc        <= '0;
    end else if (load) begin
      tx_vld     <= rx.src_rdy;
      data_q     <= rx.data;
      sof_pos_q  <= rx.sof_pos;
      eof_pos_q  <= rx.eof_pos;
      sof_q      <= rx.sof;
      eof_q      <= rx.eof;
      TX_LEN     <= len_w;
      TX_LEN_SAT <= sat_w;
      if (rx.src_rdy) begin
        in_frame <= open_c[REGIONS];
        acc      <= open_c[REGIONS] ? acc_next : '0;
      end
    end
  end

endmodule

// File: tb/tb_ptc_mfb_frame_len_meter.sv
// Directed and random bench for the frame length meter, checked against an absolute-item-position model.
module tb_ptc_mfb_frame_len_meter;
  import ptc_frame_pkg::*;

  localparam int NREG = 2;
  localparam int LW_A = 16;
  localparam int LW_B = 6;
  localparam int WI   = 16;
  localparam int DW   = 512;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic          RESET_N;
  logic [DW-1:0] d_data;
  logic [1:0]    d_sofp;
  logic [5:0]    d_eofp;
  logic [1:0]    d_sof;
  logic [1:0]    d_eof;
  logic          d_vld;
  int            d_sel;
  logic          tx_rdy;

  ptc_mfb_frame_len_meter_if #(.REGIONS(2), .REGION_SIZE(1), .BLOCK_SIZE(8), .ITEM_WIDTH(32)) rx_a ();
  ptc_mfb_frame_len_meter_if #(.REGIONS(2), .REGION_SIZE(1), .BLOCK_SIZE(8), .ITEM_WIDTH(32)) tx_a ();
  ptc_mfb_frame_len_meter_if #(.REGIONS(2), .REGION_SIZE(1), .BLOCK_SIZE(8), .ITEM_WIDTH(32)) rx_b ();
  ptc_mfb_frame_len_meter_if #(.REGIONS(2), .REGION_SIZE(1), .BLOCK_SIZE(8), .ITEM_WIDTH(32)) tx_b ();

  assign rx_a.data = d_data;  assign rx_a.sof_pos = d_sofp; assign rx_a.eof_pos = d_eofp;
  assign rx_a.sof  = d_sof;   assign rx_a.eof     = d_eof;  assign rx_a.src_rdy = d_vld && (d_sel == 0);
  assign rx_b.data = d_data;  assign rx_b.sof_pos = d_sofp; assign rx_b.eof_pos = d_eofp;
  assign rx_b.sof  = d_sof;   assign rx_b.eof     = d_eof;  assign rx_b.src_rdy = d_vld && (d_sel == 1);
  assign tx_a.dst_rdy = tx_rdy;
  assign tx_b.dst_rdy = tx_rdy;

  logic [NREG*LW_A-1:0] len_a;
  logic [NREG-1:0]      sat_a;
  logic [NREG*LW_B-1:0] len_b;
  logic [NREG-1:0]      sat_b;

  ptc_mfb_frame_len_meter #(.REGIONS(2), .REGION_SIZE(1), .BLOCK_SIZE(8), .ITEM_WIDTH(32), .LEN_WIDTH(LW_A)) dut_a (
    .CLK(CLK), .RESET_N(RESET_N), .rx(rx_a), .tx(tx_a), .TX_LEN(len_a), .TX_LEN_SAT(sat_a));
  ptc_mfb_frame_len_meter #(.REGIONS(2), .REGION_SIZE(1), .BLOCK_SIZE(8), .ITEM_WIDTH(32), .LEN_WIDTH(LW_B)) dut_b (
    .CLK(CLK), .RESET_N(RESET_N), .rx(rx_b), .tx(tx_b), .TX_LEN(len_b), .TX_LEN_SAT(sat_b));

  typedef struct packed {
    logic [DW-1:0]     data;
    logic [1:0]        sofp;
    logic [5:0]        eofp;
    logic [1:0]        sof;
    logic [1:0]        eof;
    logic [1:0][15:0]  len;
    logic [1:0]        sat;
  } exp_t;

  exp_t   q0[$];
  exp_t   q1[$];
  bit     m_open [2];
  longint m_start[2];
  longint m_wc   [2];
  int     n_asserts;
  int     n_fail;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_asserts++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frames are tracked by absolute item position in the accepted stream.
  task automatic m_close(input int sel, input int r, input longint eabs, input longint lmax, inout exp_t e);
    longint l;
    if (m_open[sel]) begin
      l = eabs - m_start[sel] + 1;
      if (l > lmax) begin
        e.len[r] = 16'(lmax);
        e.sat[r] = 1'b1;
      end else begin
        e.len[r] = 16'(l);
      end
    end
    m_open[sel] = 1'b0;
  endtask

  task automatic model_word(input int sel, output exp_t e);
    longint lmax, base, sabs, eabs;
    lmax   = (longint'(1) << ((sel == 1) ? LW_B : LW_A)) - 1;
    e.data = d_data;
    e.sofp = d_sofp;
    e.eofp = d_eofp;
    e.sof  = d_sof;
    e.eof  = d_eof;
    e.len  = '0;
    e.sat  = '0;
    for (int r = 0; r < NREG; r++) begin
      base = m_wc[sel] * WI + r * 8;
      sabs = base + longint'(d_sofp[r]) * 8;
      eabs = base + longint'(d_eofp[r*3 +: 3]);
      if (d_sof[r] && d_eof[r] && m_open[sel]) begin
        m_close(sel, r, eabs, lmax, e);
        m_open[sel] = 1'b1; m_start[sel] = sabs;
      end else if (d_sof[r] && d_eof[r]) begin
        m_open[sel] = 1'b1; m_start[sel] = sabs;
        m_close(sel, r, eabs, lmax, e);
      end else if (d_sof[r]) begin
        m_open[sel] = 1'b1; m_start[sel] = sabs;
      end else if (d_eof[r]) begin
        m_close(sel, r, eabs, lmax, e);
      end
    end
    m_wc[sel]++;
  endtask

  task automatic cycle(input bit dst, output bit acc_in);
    exp_t             e, f;
    logic [DW-1:0]    o_data;
    logic [1:0]       o_sofp, o_sof, o_eof, o_sat;
    logic [5:0]       o_eofp;
    logic [1:0][15:0] o_len;
    logic             o_vld, o_rdy;
    int               qs;
    tx_rdy = dst;
    #1;
    f = '0;
    if (d_sel == 0) begin
      o_data = tx_a.data; o_sofp = tx_a.sof_pos; o_eofp = tx_a.eof_pos;
      o_sof = tx_a.sof; o_eof = tx_a.eof; o_sat = sat_a;
      o_len[0] = len_a[15:0]; o_len[1] = len_a[31:16];
      o_vld = tx_a.src_rdy; o_rdy = rx_a.dst_rdy;
      qs = q0.size(); if (qs > 0) f = q0[0];
    end else begin
      o_data = tx_b.data; o_sofp = tx_b.sof_pos; o_eofp = tx_b.eof_pos;
      o_sof = tx_b.sof; o_eof = tx_b.eof; o_sat = sat_b;
      o_len[0] = 16'(len_b[5:0]); o_len[1] = 16'(len_b[11:6]);
      o_vld = tx_b.src_rdy; o_rdy = rx_b.dst_rdy;
      qs = q1.size(); if (qs > 0) f = q1[0];
    end
    check("tx_src_rdy", o_vld, qs != 0);
    check("rx_dst_rdy", o_rdy, dst || (qs == 0));
    if (qs > 0) begin
      check("tx_data", o_data, f.data);
      check("tx_sof_pos", o_sofp, f.sofp);
      check("tx_eof_pos", o_eofp, f.eofp);
      check("tx_sof", o_sof, f.sof);
      check("tx_eof", o_eof, f.eof);
      check("tx_len0", o_len[0], f.len[0]);
      check("tx_len1", o_len[1], f.len[1]);
      check("tx_len_sat", o_sat, f.sat);
      if (dst) begin
        if (d_sel == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
    end
    acc_in = d_vld && (dst || (qs == 0));
    if (acc_in) begin
      model_word(d_sel, e);
      if (d_sel == 0) q0.push_back(e); else q1.push_back(e);
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic set_word(input logic [1:0] sof, input logic [1:0] eof, input logic [2:0] e0, input logic [2:0] e1);
    for (int i = 0; i < 16; i++) d_data[i*32 +: 32] = $urandom();
    d_sofp = 2'b00;
    d_sof  = sof;
    d_eof  = eof;
    d_eofp = {e1, e0};
    d_vld  = 1'b1;
  endtask

  task automatic send(input bit rnd_dst);
    bit a;
    int n;
    n = 0;
    do begin
      cycle(rnd_dst ? ($urandom_range(0, 3) != 0) : 1'b1, a);
      n++;
    end while (!a && n < 64);
    check("send_accept", a, 1'b1);
    d_vld = 1'b0;
  endtask

  task automatic flush();
    bit a;
    d_vld = 1'b0;
    repeat (3) cycle(1'b1, a);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    n_asserts = 0; n_fail = 0;
    RESET_N = 1'b0;
    d_data = '0; d_sofp = '0; d_eofp = '0; d_sof = '0; d_eof = '0;
    d_vld = 1'b0; d_sel = 0; tx_rdy = 1'b1;
    for (int s = 0; s < 2; s++) begin m_open[s] = 0; m_start[s] = 0; m_wc[s] = 0; end

    #12;
    check("rst_src_rdy", tx_a.src_rdy, 1'b0);
    check("rst_eof", tx_a.eof, 2'b00);
    check("rst_len", len_a, 32'd0);
    check("rst_data", tx_a.data, '0);
    @(negedge CLK);
    RESET_N = 1'b1;
    flush();

    // single-region frame
    set_word(2'b01, 2'b01, 3'd5, 3'd0);
    send(1'b0);
    check("t1_eof", tx_a.eof, 2'b01);
    check("t1_len0", len_a[15:0], 16'd6);
    check("t1_len1", len_a[31:16], 16'd0);
    flush();

    // frame across three words
    set_word(2'b10, 2'b00, 3'd0, 3'd0); send(1'b0);
    set_word(2'b00, 2'b00, 3'd0, 3'd0); send(1'b0);
    set_word(2'b00, 2'b01, 3'd3, 3'd0); send(1'b0);
    check("t2_len0", len_a[15:0], 16'd28);
    flush();

    // EOF then SOF+EOF in one word
    set_word(2'b10, 2'b00, 3'd0, 3'd0); send(1'b0);
    set_word(2'b10, 2'b11, 3'd7, 3'd2); send(1'b0);
    check("t3_len0", len_a[15:0], 16'd16);
    check("t3_len1", len_a[31:16], 16'd3);
    flush();

    // backpressure in a 3-word frame
    set_word(2'b01, 2'b00, 3'd0, 3'd0); send(1'b0);
    set_word(2'b00, 2'b00, 3'd0, 3'd0);
    repeat (5) cycle(1'b0, a);
    send(1'b0);
    set_word(2'b00, 2'b01, 3'd7, 3'd0); send(1'b0);
    check("t4_len0", len_a[15:0], 16'd40);
    flush();

    // saturation on the narrow length instance
    d_sel = 1;
    set_word(2'b01, 2'b00, 3'd0, 3'd0); send(1'b0);
    repeat (3) begin set_word(2'b00, 2'b00, 3'd0, 3'd0); send(1'b0); end
    set_word(2'b00, 2'b10, 3'd0, 3'd7); send(1'b0);
    check("t5_len1", len_b[11:6], 6'd63);
    check("t5_sat", sat_b, 2'b10);
    flush();
    d_sel = 0;

    // reset mid-frame, then an orphan EOF
    set_word(2'b10, 2'b00, 3'd0, 3'd0); send(1'b0);
    RESET_N = 1'b0;
    #1;
    check("t6_src_rdy", tx_a.src_rdy, 1'b0);
    check("t6_sof", tx_a.sof, 2'b00);
    check("t6_len", len_a, 32'd0);
    check("t6_data", tx_a.data, '0);
    for (int s = 0; s < 2; s++) m_open[s] = 0;
    q0.delete(); q1.delete();
    @(posedge CLK); @(negedge CLK);
    RESET_N = 1'b1;
    set_word(2'b00, 2'b01, 3'd4, 3'd0); send(1'b0);
    check("t6_orphan_len", len_a[15:0], 16'd0);
    check("t6_orphan_sat", sat_a, 2'b00);
    check("t6_orphan_data", tx_a.data, d_data);
    flush();

    // random traffic on both instances
    for (int s = 0; s < 2; s++) begin
      d_sel = s;
      for (int i = 0; i < ((s == 0) ? 400 : 150); i++) begin
        set_word({($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)},
                 {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)},
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        send(1'b1);
        if ($urandom_range(0, 4) == 0) cycle($urandom_range(0, 1) == 1, a);
      end
      flush();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
